// File: rtl/elevator_scheduler.sv
// N-floor SCAN elevator car controller: latches car/hall calls, drives motor, door and floor outputs.
// Latency: button-to-requests 1 edge; all outputs registered. No backpressure: calls are level-sampled every cycle.
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3,
  localparam int FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] inDoorButtons,
  input  logic [NUM_FLOORS-1:0] outDoorButtons,
  input  logic                  req_enable,
  output logic [FLOOR_W-1:0]    currentFloor,
  output logic [1:0]            motor,
  output logic                  doorState,
  output logic [NUM_FLOORS-1:0] requests,
  output logic                  busy
);

  localparam int MOVE_W = $clog2(MOVE_CYCLES + 1);
  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t              state, state_nxt;
  logic                dir, dir_nxt;          // 1 = up
  logic [MOVE_W-1:0]   move_cnt, move_cnt_nxt;
  logic [DOOR_W-1:0]   door_cnt, door_cnt_nxt;
  logic [FLOOR_W-1:0]  floor_nxt, next_floor;
  logic [1:0]          motor_nxt;
  logic                door_nxt;
  logic [NUM_FLOORS-1:0] set_v, pend, clear, req_nxt, cur_oh, next_oh;
  logic                above, below;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dir          <= 1'b1;
      move_cnt     <= '0;
      door_cnt     <= '0;
      currentFloor <= '0;
      motor        <= MOTOR_STOP;
      doorState    <= 1'b0;
      requests     <= '0;
    end else begin
      state        <= state_nxt;
      dir          <= dir_nxt;
      move_cnt     <= move_cnt_nxt;
      door_cnt     <= door_cnt_nxt;
      currentFloor <= floor_nxt;
      motor        <= motor_nxt;
      doorState    <= door_nxt;
      requests     <= req_nxt;
    end
  end

  always_comb begin
    set_v      = outDoorButtons | (inDoorButtons & {NUM_FLOORS{req_enable}});
    pend       = requests | set_v;
    cur_oh     = NUM_FLOORS'(1) << currentFloor;
    next_floor = dir ? currentFloor + 1'b1 : currentFloor - 1'b1;
    next_oh    = NUM_FLOORS'(1) << next_floor;
    above      = 1'b0;
    below      = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(currentFloor)) above = above | requests[i];
      if (i < int'(currentFloor)) below = below | requests[i];
    end

    state_nxt    = state;
    dir_nxt      = dir;
    move_cnt_nxt = move_cnt;
    door_cnt_nxt = door_cnt;
    floor_nxt    = currentFloor;
    motor_nxt    = motor;
    door_nxt     = doorState;
    clear        = '0;

    case (state)
      IDLE: begin
        motor_nxt = MOTOR_STOP;
        door_nxt  = 1'b0;
        if (requests[currentFloor]) begin
          state_nxt    = DOOR;
          door_nxt     = 1'b1;
          door_cnt_nxt = '0;
          clear        = cur_oh;
        end else if (above && (dir || !below)) begin
          state_nxt    = MOVE;
          dir_nxt      = 1'b1;
          motor_nxt    = MOTOR_UP;
          move_cnt_nxt = '0;
        end else if (below) begin
          state_nxt    = MOVE;
          dir_nxt      = 1'b0;
          motor_nxt    = MOTOR_DOWN;
          move_cnt_nxt = '0;
        end
      end

      MOVE: begin
        if (move_cnt != MOVE_W'(MOVE_CYCLES - 1)) begin
          move_cnt_nxt = move_cnt + 1'b1;
        end else begin
          move_cnt_nxt = '0;
          // Unreachable while a call lies ahead; keeps the floor index in range regardless.
          if ((dir && currentFloor == TOP_FLOOR) || (!dir && currentFloor == '0)) begin
            state_nxt = IDLE;
            motor_nxt = MOTOR_STOP;
          end else begin
            floor_nxt = next_floor;
            if (next_floor == TOP_FLOOR) dir_nxt = 1'b0;
            if (next_floor == '0)        dir_nxt = 1'b1;
            if (pend[next_floor]) begin
              state_nxt    = DOOR;
              motor_nxt    = MOTOR_STOP;
              door_nxt     = 1'b1;
              door_cnt_nxt = '0;
              clear        = next_oh;
            end
          end
        end
      end

      DOOR: begin
        // A press at this floor while open just extends the dwell.
        if (set_v[currentFloor]) begin
          door_cnt_nxt = '0;
          clear        = cur_oh;
        end else if (door_cnt == DOOR_W'(DOOR_CYCLES - 1)) begin
          state_nxt    = IDLE;
          door_nxt     = 1'b0;
          door_cnt_nxt = '0;
        end else begin
          door_cnt_nxt = door_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        motor_nxt = MOTOR_STOP;
        door_nxt  = 1'b0;
      end
    endcase

    req_nxt = (requests | set_v) & ~clear;
  end

  assign busy = (state != IDLE) || (|requests);

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Parametrised N-floor elevator car controller: the next generation of the fixed three-floor floor/motor/door logic behind the keypad-login front end. It latches car and hall calls into a pending-request vector, serves them in SCAN order (keep direction while calls remain ahead, then reverse), and drives the motor, door and current-floor outputs with per-floor travel and door-dwell timers. The login front end gates car-button requests through `req_enable`; hall calls are always accepted.

## Interface
- `NUM_FLOORS`, 8: number of floors, ≥2; floors numbered 0..NUM_FLOORS-1.
- `MOVE_CYCLES`, 4: clock cycles to travel one floor, ≥1.
- `DOOR_CYCLES`, 3: cycles the door stays open per stop, ≥1.
- `FLOOR_W`, $clog2(NUM_FLOORS): width of the floor index (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inDoorButtons`  in  NUM_FLOORS  car buttons, bit i = floor i; level-sampled each cycle.
- `outDoorButtons`  in  NUM_FLOORS  hall call buttons, bit i = floor i.
- `req_enable`  in  1  1 = car buttons accepted (user logged in); hall buttons ignore it.
- `currentFloor`  out  FLOOR_W  floor the car is at or last passed.
- `motor`  out  2  00 stop, 01 up, 10 down; 11 never driven.
- `doorState`  out  1  1 = door open.
- `requests`  out  NUM_FLOORS  registered pending-call vector.
- `busy`  out  1  1 when state ≠ IDLE or `requests` ≠ 0.

## Operation
- Reset (rst=0, asynchronous): state IDLE, `currentFloor`=0, `motor`=00, `doorState`=0, `requests`=0, direction=up, both counters 0.
- Request capture each edge: `set = outDoorButtons | (inDoorButtons & {NUM_FLOORS{req_enable}})`; `requests <= (requests | set) & ~clear`. Clear beats set on the same bit.
- States: IDLE, MOVE, DOOR.
- IDLE:
  - `requests`=0: stay.
  - `requests[currentFloor]`: → DOOR; clear that bit; `doorState`=1.
  - Else calls above and (dir=up or no calls below): dir=up, → MOVE, `motor`=01.
  - Else: dir=down, → MOVE, `motor`=10.
- MOVE: move counter counts 0..MOVE_CYCLES-1. On terminal count: `currentFloor` ±1 per dir, counter to 0. If `requests[new floor]` (including a set arriving that edge): → DOOR, `motor`=00, `doorState`=1, bit cleared, all on the same edge. Otherwise stay in MOVE in the same direction. A pending call ahead is guaranteed, because bits clear only at stops.
- DOOR: door counter counts 0..DOOR_CYCLES-1. Any `set` bit for `currentFloor` restarts the counter at 0 and is cleared, never left pending. On terminal count: → IDLE, `doorState`=0.
- Invariants:
  - `motor`≠00 only in MOVE.
  - `doorState`=1 only in DOOR.
  - `motor` and `doorState` never both active.
  - `currentFloor` never leaves 0..NUM_FLOORS-1.
  - At floor 0, dir is never down; at the top floor, dir is never up.
- Reset mid-travel: the car returns to floor 0 logically with `requests` lost. This is accepted behaviour.

## Timing
- All outputs are registered; no combinational path from input to output.
- Button-to-`requests` latency: 1 edge.
- Call at current floor in IDLE, seen at edge t: `doorState`=1 after edge t+1.
- Call at floor k≠cur in IDLE, captured at edge t:
  - `motor` set at edge t+1.
  - Arrival and door open at edge t+1+MOVE_CYCLES·|k−cur|.
  - Door closes DOOR_CYCLES edges after opening.
- DOOR→IDLE→next decision costs 1 idle cycle, with `motor`=00 and `doorState`=0.
- Simultaneous calls above and below in IDLE with dir=up: up wins. With dir=down: down wins.
- Button held high is idempotent: it re-sets the bit each cycle until served. Held at the current floor during DOOR, it keeps the door open indefinitely.

## Test plan
Bench parameters: NUM_FLOORS=4, MOVE_CYCLES=4, DOOR_CYCLES=3.
- Reset: rst low mid-MOVE → outputs 0/00/0/0 immediately, without waiting for clk; rst high → IDLE.
- Single call: car at 0, `outDoorButtons`=0100 one cycle → `motor`=01 next edge; `currentFloor` 1 at +5 and 2 at +9 edges; door opens the same edge as floor 2; open 3 cycles; `requests`=0.
- Gating: `inDoorButtons`=1000 with `req_enable`=0 → `requests` stays 0; repeated with `req_enable`=1 → bit 3 set, car travels to 3.
- SCAN order: car at 1 moving up toward 3, hall call at 0 and car call at 2 → stops at 2, then 3, then reverses to 0; three door openings in that order.
- Door extend: door open at floor 2, `outDoorButtons`=0100 pulsed on dwell cycle 2 → door stays open 3 further cycles; `requests[2]` never set.
- Tie/bounds: IDLE at floor 0 after reset, calls at 3 and 0 together → door opens at 0 first, then up to 3; `motor` is never 10 at floor 0.
